// File: rtl/tri_frame_if.sv
// Host write / commit channel and presented-triangle outputs of tri_frame_sequencer.
interface tri_frame_if #(
    parameter int unsigned MAX_TRIS = 4
);
    localparam int unsigned IW = $clog2(MAX_TRIS);

    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_index;
    logic [59:0]   wr_data;
    logic [2:0]    wr_color;
    logic [IW:0]   wr_count;
    logic          commit_req;
    logic          commit_done;
    logic [59:0]   geometry;
    logic [2:0]    color;
    logic          geom_valid;
    logic [IW-1:0] tri_index;
    logic          frame_parity;

    modport master (
        output wr_valid, wr_index, wr_data, wr_color, wr_count, commit_req,
        input  wr_ready, commit_done, geometry, color, geom_valid, tri_index, frame_parity
    );

    modport slave (
        input  wr_valid, wr_index, wr_data, wr_color, wr_count, commit_req,
        output wr_ready, commit_done, geometry, color, geom_valid, tri_index, frame_parity
    );
endinterface

// File: rtl/tri_frame_sequencer.sv
// Frame-level triangle scheduler with a double-buffered table committed at frame start.
// Optional macro TRI_COLOR_EN adds per-slot colour storage.
module tri_frame_sequencer #(
    parameter int unsigned MAX_TRIS    = 4,
    parameter int unsigned HOLD_FRAMES = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     vsync,
    tri_frame_if.slave bus
);
    localparam int unsigned IW = $clog2(MAX_TRIS);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned AW = IW + 1;
    localparam int unsigned HW = 4;
    localparam int unsigned DW = 60;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_n;
    logic          bank_q, bank_n;
    logic [CW-1:0] count_q, count_n;
    logic [CW-1:0] pcount_q, pcount_n;
    logic          pend_q, pend_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [IW-1:0] idx_q, idx_n;
    logic [CW-1:0] idx_inc;
    logic          parity_q, parity_n;
    logic          done_q, done_n;
    logic          ready_q, ready_n;
    logic          vsync_q;
    logic          fs_c;

    logic [DW-1:0] geom_mem [2*MAX_TRIS];

    assign fs_c = !vsync_q && vsync;

    assign bus.tri_index    = idx_q;
    assign bus.frame_parity = parity_q;
    assign bus.commit_done  = done_q;
    assign bus.wr_ready     = ready_q;

    // Next-state: bank swap on a pending commit, otherwise hold/advance rotation.
    always_comb begin
        state_n  = state_q;
        bank_n   = bank_q;
        count_n  = count_q;
        pcount_n = pcount_q;
        pend_n   = pend_q;
        hold_n   = hold_q;
        idx_n    = idx_q;
        parity_n = parity_q;
        done_n   = 1'b0;
        idx_inc  = CW'(idx_q) + CW'(1);

        if (fs_c) begin
            parity_n = ~parity_q;
            if (pend_q) begin
                bank_n  = ~bank_q;
                count_n = pcount_q;
                idx_n   = '0;
                hold_n  = '0;
                pend_n  = 1'b0;
                done_n  = 1'b1;
            end else if (state_q == RUN) begin
                if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                    hold_n = '0;
                    idx_n  = (idx_inc >= count_q) ? '0 : IW'(idx_inc);
                end else begin
                    hold_n = hold_q + HW'(1);
                end
            end
        end

        // A request while one is outstanding is dropped; the first count stands.
        if (bus.commit_req && !pend_q) begin
            pend_n   = 1'b1;
            pcount_n = (bus.wr_count > CW'(MAX_TRIS)) ? CW'(MAX_TRIS) : bus.wr_count;
        end

        ready_n = !pend_n && !done_n;
        state_n = (count_n != '0) ? RUN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q  <= 1'b1;
            state_q  <= IDLE;
            bank_q   <= 1'b0;
            count_q  <= '0;
            pcount_q <= '0;
            pend_q   <= 1'b0;
            hold_q   <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            vsync_q  <= vsync;
            state_q  <= state_n;
            bank_q   <= bank_n;
            count_q  <= count_n;
            pcount_q <= pcount_n;
            pend_q   <= pend_n;
            hold_q   <= hold_n;
            idx_q    <= idx_n;
            parity_q <= parity_n;
            done_q   <= done_n;
            ready_q  <= ready_n;
        end
    end

    // Host writes always target the shadow bank.
    always_ff @(posedge clk) begin
        if (!reset && bus.wr_valid && ready_q)
            geom_mem[{~bank_q, bus.wr_index}] <= bus.wr_data;
    end

    // Presented geometry lags tri_index by one clock and is frozen for the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.geometry   <= '0;
            bus.geom_valid <= 1'b0;
        end else begin
            bus.geometry   <= (state_q == RUN) ? geom_mem[AW'({bank_q, idx_q})] : '0;
            bus.geom_valid <= (state_q == RUN);
        end
    end

`ifdef TRI_COLOR_EN
    logic [2:0] color_mem [2*MAX_TRIS];

    always_ff @(posedge clk) begin
        if (!reset && bus.wr_valid && ready_q)
            color_mem[{~bank_q, bus.wr_index}] <= bus.wr_color;
    end

    always_ff @(posedge clk) begin
        if (reset)
            bus.color <= '0;
        else
            bus.color <= (state_q == RUN) ? color_mem[AW'({bank_q, idx_q})] : 3'b000;
    end
`else
    logic unused_color;
    assign unused_color = ^bus.wr_color;

    always_ff @(posedge clk) begin
        if (reset)
            bus.color <= '0;
        else
            bus.color <= (state_q == RUN) ? ({2'b00, parity_q} | 3'b001) : 3'b000;
    end
`endif
endmodule

// File: tb/tb_tri_frame_sequencer.sv
// Self-checking bench for tri_frame_sequencer: vector table, corner sequences, random vs model.
module tb_tri_frame_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic vsync;
    always #5 clk = ~clk;

    tri_frame_if #(.MAX_TRIS(4)) bus1 ();
    tri_frame_if #(.MAX_TRIS(4)) bus3 ();

    assign bus3.wr_valid   = bus1.wr_valid;
    assign bus3.wr_index   = bus1.wr_index;
    assign bus3.wr_data    = bus1.wr_data;
    assign bus3.wr_color   = bus1.wr_color;
    assign bus3.wr_count   = bus1.wr_count;
    assign bus3.commit_req = bus1.commit_req;

    tri_frame_sequencer #(.MAX_TRIS(4), .HOLD_FRAMES(1)) dut1 (
        .clk(clk), .reset(reset), .vsync(vsync), .bus(bus1));
    tri_frame_sequencer #(.MAX_TRIS(4), .HOLD_FRAMES(3)) dut3 (
        .clk(clk), .reset(reset), .vsync(vsync), .bus(bus3));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: banks, frames elapsed since the last commit, pending request.
    logic [59:0] mgeom [2][4];
    logic [2:0]  mcol  [2][4];
    int mact = 0, mcount = 0, mframes = 0, mpcount = 0;
    bit mpend = 0, mpar = 0, mvq = 1;
    logic [59:0] e_geom1 = '0, e_geom3 = '0;
    logic [2:0]  e_col1 = '0, e_col3 = '0;
    logic        e_valid = 0, e_par = 0, e_done = 0, e_ready = 1;
    int          e_idx1 = 0, e_idx3 = 0;

    function automatic int midx(int h);
        return (mcount > 0) ? (mframes / h) % mcount : 0;
    endfunction

    function automatic logic [59:0] pk(int a, int b, int c, int d, int e, int f);
        return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f)};
    endfunction

    task automatic step();
        int i1, i3;
        bit fs, pend0;
        @(posedge clk);
        if (reset) begin
            mact = 0; mcount = 0; mframes = 0; mpend = 0; mpar = 0; mvq = 1;
            e_geom1 = '0; e_geom3 = '0; e_col1 = '0; e_col3 = '0;
            e_valid = 0; e_par = 0; e_done = 0; e_ready = 1; e_idx1 = 0; e_idx3 = 0;
        end else begin
            i1 = midx(1);
            i3 = midx(3);
            e_valid = (mcount > 0);
            e_geom1 = e_valid ? mgeom[mact][i1] : '0;
            e_geom3 = e_valid ? mgeom[mact][i3] : '0;
`ifdef TRI_COLOR_EN
            e_col1 = e_valid ? mcol[mact][i1] : 3'b000;
            e_col3 = e_valid ? mcol[mact][i3] : 3'b000;
`else
            e_col1 = e_valid ? 3'b001 : 3'b000;
            e_col3 = e_col1;
`endif
            fs = !mvq && vsync;
            pend0 = mpend;
            if (bus1.wr_valid && e_ready) begin
                mgeom[1-mact][bus1.wr_index] = bus1.wr_data;
                mcol[1-mact][bus1.wr_index]  = bus1.wr_color;
            end
            e_done = 0;
            if (fs) begin
                mpar = !mpar;
                if (pend0) begin
                    mact = 1 - mact; mcount = mpcount; mframes = 0; mpend = 0; e_done = 1;
                end else if (mcount > 0) begin
                    mframes++;
                end
            end
            if (bus1.commit_req && !pend0) begin
                mpend = 1;
                mpcount = (int'(bus1.wr_count) > 4) ? 4 : int'(bus1.wr_count);
            end
            e_ready = !(mpend || e_done);
            e_par = mpar;
            e_idx1 = midx(1);
            e_idx3 = midx(3);
            mvq = vsync;
        end
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(logic rst, logic vs, logic wv, logic [1:0] wi, logic [59:0] wd,
                          logic cr, logic [2:0] wc);
        reset = rst;
        vsync = vs;
        bus1.wr_valid   = wv;
        bus1.wr_index   = wi;
        bus1.wr_data    = wd;
        bus1.wr_color   = 3'(wi) + 3'd1;
        bus1.commit_req = cr;
        bus1.wr_count   = wc;
    endtask

    task automatic idle(logic vs);
        set_in(1'b0, vs, 1'b0, 2'd0, '0, 1'b0, 3'd0);
    endtask

    typedef struct {
        logic rst, vs, wv;
        logic [1:0] wi;
        logic [59:0] wd;
        logic cr;
        logic [2:0] wc;
        logic e_done, e_valid;
        logic [1:0] e_idx;
        logic e_par, e_ready;
        logic [59:0] e_geom;
    } vec_t;

    function automatic vec_t mkv(logic rst, logic vs, logic wv, logic [1:0] wi, logic [59:0] wd,
                                 logic cr, logic [2:0] wc, logic ed, logic ev, logic [1:0] ei,
                                 logic ep, logic er, logic [59:0] eg);
        vec_t v;
        v.rst = rst; v.vs = vs; v.wv = wv; v.wi = wi; v.wd = wd; v.cr = cr; v.wc = wc;
        v.e_done = ed; v.e_valid = ev; v.e_idx = ei; v.e_par = ep; v.e_ready = er; v.e_geom = eg;
        return v;
    endfunction

    initial begin
        vec_t vecs [15];
        logic [59:0] g0, g1, n0;
        logic [59:0] s [3];
        logic [59:0] h [4];
        int exp3 [10];

        g0 = pk(100, 1, 1, 100, 200, 200);
        g1 = pk(300, 100, 250, 300, 400, 300);
        n0 = pk(7, 8, 9, 10, 11, 12);
        for (int i = 0; i < 3; i++) s[i] = pk(10*i+1, 10*i+2, 10*i+3, 10*i+4, 10*i+5, 10*i+6);
        for (int i = 0; i < 4; i++) h[i] = pk(500+i, 400+i, 300+i, 200+i, 100+i, i);
        exp3 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};

        //               rst vs wv wi  wd   cr wc | done valid idx par ready geom
        vecs[0]  = mkv(1, 0, 0, 0, '0, 0, 0,   0, 0, 0, 0, 1, '0);
        vecs[1]  = mkv(0, 0, 0, 0, '0, 0, 0,   0, 0, 0, 0, 1, '0);
        vecs[2]  = mkv(0, 1, 0, 0, '0, 0, 0,   0, 0, 0, 1, 1, '0);
        vecs[3]  = mkv(0, 0, 0, 0, '0, 0, 0,   0, 0, 0, 1, 1, '0);
        vecs[4]  = mkv(0, 1, 0, 0, '0, 0, 0,   0, 0, 0, 0, 1, '0);
        vecs[5]  = mkv(0, 0, 1, 0, g0, 0, 0,   0, 0, 0, 0, 1, '0);
        vecs[6]  = mkv(0, 0, 1, 1, g1, 1, 2,   0, 0, 0, 0, 0, '0);
        vecs[7]  = mkv(0, 0, 0, 0, '0, 0, 0,   0, 0, 0, 0, 0, '0);
        vecs[8]  = mkv(0, 1, 0, 0, '0, 0, 0,   1, 0, 0, 1, 0, '0);
        vecs[9]  = mkv(0, 1, 0, 0, '0, 0, 0,   0, 1, 0, 1, 1, g0);
        vecs[10] = mkv(0, 0, 0, 0, '0, 0, 0,   0, 1, 0, 1, 1, g0);
        vecs[11] = mkv(0, 1, 0, 0, '0, 0, 0,   0, 1, 1, 0, 1, g0);
        vecs[12] = mkv(0, 0, 0, 0, '0, 0, 0,   0, 1, 1, 0, 1, g1);
        vecs[13] = mkv(0, 1, 0, 0, '0, 0, 0,   0, 1, 0, 1, 1, g1);
        vecs[14] = mkv(0, 0, 0, 0, '0, 0, 0,   0, 1, 0, 1, 1, g0);

        set_in(1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 3'd0);

        for (int r = 0; r < 15; r++) begin
            set_in(vecs[r].rst, vecs[r].vs, vecs[r].wv, vecs[r].wi, vecs[r].wd,
                   vecs[r].cr, vecs[r].wc);
            step();
            chk($sformatf("vec%0d commit_done", r), 64'(bus1.commit_done), 64'(vecs[r].e_done));
            chk($sformatf("vec%0d geom_valid", r), 64'(bus1.geom_valid), 64'(vecs[r].e_valid));
            chk($sformatf("vec%0d tri_index", r), 64'(bus1.tri_index), 64'(vecs[r].e_idx));
            chk($sformatf("vec%0d frame_parity", r), 64'(bus1.frame_parity), 64'(vecs[r].e_par));
            chk($sformatf("vec%0d wr_ready", r), 64'(bus1.wr_ready), 64'(vecs[r].e_ready));
            chk($sformatf("vec%0d geometry", r), 64'(bus1.geometry), 64'(vecs[r].e_geom));
        end

        // Hold of three frames with three triangles.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 2'(i), s[i], (i == 2), 3'd3);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            step();
            if (i == 0) chk("hold3 commit_done", 64'(bus3.commit_done), 64'd1);
            chk($sformatf("hold3 idx fs%0d", i), 64'(bus3.tri_index), 64'(exp3[i]));
            chk($sformatf("hold1 idx fs%0d", i), 64'(bus1.tri_index), 64'(i % 3));
            idle(1'b0);
            step();
        end
        chk("hold1 geom after rotation", 64'(bus1.geometry), 64'(s[0]));

        // Shadow write mid-frame and a doubled commit request.
        set_in(1'b0, 1'b0, 1'b1, 2'd0, n0, 1'b0, 3'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            step();
            chk($sformatf("shadow frozen %0d", i), 64'(bus1.geometry), 64'(s[0]));
        end
        set_in(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1, 3'd1);
        step();
        chk("ready low after req", 64'(bus1.wr_ready), 64'd0);
        set_in(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1, 3'd3);
        step();
        chk("ready low second req", 64'(bus1.wr_ready), 64'd0);
        chk("no early done", 64'(bus1.commit_done), 64'd0);
        idle(1'b1);
        step();
        chk("single commit_done", 64'(bus1.commit_done), 64'd1);
        chk("geom held at swap", 64'(bus1.geometry), 64'(s[0]));
        idle(1'b0);
        step();
        chk("done is one pulse", 64'(bus1.commit_done), 64'd0);
        chk("new geom after swap", 64'(bus1.geometry), 64'(n0));
        chk("ready back", 64'(bus1.wr_ready), 64'd1);
        idle(1'b1);
        step();
        chk("no second done", 64'(bus1.commit_done), 64'd0);
        chk("first count stands", 64'(bus1.tri_index), 64'd0);

        // Commit of an empty table.
        set_in(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1, 3'd0);
        step();
        idle(1'b1);
        step();
        chk("empty commit done", 64'(bus1.commit_done), 64'd1);
        idle(1'b0);
        step();
        chk("empty valid", 64'(bus1.geom_valid), 64'd0);
        chk("empty geometry", 64'(bus1.geometry), 64'd0);
        chk("empty color", 64'(bus1.color), 64'd0);

        // Count saturation to the table depth.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 2'(i), h[i], (i == 3), 3'd7);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            step();
            chk($sformatf("sat idx fs%0d", i), 64'(bus1.tri_index), 64'(i % 4));
            idle(1'b0);
            step();
            chk($sformatf("sat geom fs%0d", i), 64'(bus1.geometry), 64'(h[i % 4]));
        end

        // Reset while a commit is pending.
        set_in(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1, 3'd2);
        step();
        set_in(1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 3'd0);
        step();
        idle(1'b0);
        step();
        idle(1'b1);
        step();
        chk("rst pend no done", 64'(bus1.commit_done), 64'd0);
        chk("rst pend idx", 64'(bus1.tri_index), 64'd0);
        chk("rst pend parity", 64'(bus1.frame_parity), 64'd1);
        chk("rst pend ready", 64'(bus1.wr_ready), 64'd1);
        idle(1'b0);
        step();
        chk("rst pend valid", 64'(bus1.geom_valid), 64'd0);
        chk("rst pend geometry", 64'(bus1.geometry), 64'd0);

        // Fill both banks before random traffic.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                set_in(1'b0, 1'b0, 1'b1, 2'(i), {$urandom, $urandom}, (i == 3), 3'd4);
                bus1.wr_color = 3'($urandom);
                step();
            end
            idle(1'b1);
            step();
            idle(1'b0);
            step();
        end

        for (int c = 0; c < 3000; c++) begin
            reset           = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0) vsync = ~vsync;
            bus1.wr_valid   = ($urandom_range(0, 2) == 0);
            bus1.wr_index   = 2'($urandom_range(0, 3));
            bus1.wr_data    = {$urandom, $urandom};
            bus1.wr_color   = 3'($urandom);
            bus1.commit_req = ($urandom_range(0, 24) == 0);
            bus1.wr_count   = 3'($urandom_range(0, 7));
            step();
            chk("rnd geometry1", 64'(bus1.geometry), 64'(e_geom1));
            chk("rnd geometry3", 64'(bus3.geometry), 64'(e_geom3));
            chk("rnd color1", 64'(bus1.color), 64'(e_col1));
            chk("rnd color3", 64'(bus3.color), 64'(e_col3));
            chk("rnd geom_valid", 64'(bus1.geom_valid), 64'(e_valid));
            chk("rnd tri_index1", 64'(bus1.tri_index), 64'(e_idx1));
            chk("rnd tri_index3", 64'(bus3.tri_index), 64'(e_idx3));
            chk("rnd frame_parity", 64'(bus1.frame_parity), 64'(e_par));
            chk("rnd commit_done", 64'(bus1.commit_done), 64'(e_done));
            chk("rnd wr_ready", 64'(bus1.wr_ready), 64'(e_ready));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tri_frame_sequencer.md
Name: tri_frame_sequencer

Overview:
Frame-level scheduler feeding the single-triangle scanline filler. Holds a double-buffered table of up to MAX_TRIS triangles. It presents one triangle's 60-bit packed geometry per display interval and rotates through the table on frame boundaries. Host-side writes go to a shadow bank and are committed atomically at a frame start, so the filler never sees a half-updated triangle mid-frame.

Parameters:
MAX_TRIS, 4, table depth per bank (power of two, 2..16)
HOLD_FRAMES, 1, frames each triangle is displayed before advancing (1..15)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
vsync  in  1  vsync from the hvsync generator (level; edge detected internally)
wr_valid  in  1  shadow-table write request
wr_ready  out  1  write accepted this cycle when high with wr_valid
wr_index  in  $clog2(MAX_TRIS)  shadow slot to write
wr_data  in  60  packed {x0,y0,x1,y1,x2,y2}, 10 bits each, x0 in MSBs
wr_color  in  3  per-triangle RGB (see Optional Feature)
wr_count  in  $clog2(MAX_TRIS)+1  triangle count latched with commit_req
commit_req  in  1  one-cycle pulse: publish the shadow bank at the next frame start
commit_done  out  1  one-cycle pulse when the swap occurs
geometry  out  60  active triangle to the filler
color  out  3  active triangle colour
geom_valid  out  1  high when active count > 0
tri_index  out  $clog2(MAX_TRIS)  index of the presented triangle
frame_parity  out  1  toggles every frame start

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. All state is updated on the rising edge of clk; there is no clocking on vsync.
- Frame start (fs): one-cycle internal pulse when vsync_q==0 and vsync==1. vsync_q resets to 1 so reset never produces a spurious fs.
- Reset values:
  - geometry=0, color=0, geom_valid=0, tri_index=0, frame_parity=0, commit_done=0, wr_ready=1.
  - Active count=0, hold counter=0, active bank=0, commit pending=0.
  - Table contents are don't-care but must be written before use.
- States:
  - IDLE: active count==0.
  - RUN: active count>0.
  - PEND: RUN or IDLE with commit pending.
  - Pending is an orthogonal flag rather than a separate encoding.
- Writes:
  - wr_valid&&wr_ready writes wr_data/wr_color into the shadow bank at wr_index.
  - Writes with wr_index>=MAX_TRIS are impossible by width. No error output.
  - wr_ready=0 while commit pending, from the cycle after commit_req until the cycle after commit_done. This keeps the published bank frozen.
- commit_req:
  - Latches wr_count, saturated to MAX_TRIS, and sets pending.
  - commit_req while already pending is ignored; the first count stands.
  - A write and commit_req in the same cycle: the write lands first and is part of the commit.
- At fs with pending:
  - Swap banks and load active count.
  - tri_index=0, hold counter=0, clear pending.
  - Pulse commit_done in the same cycle the outputs update.
- At fs without pending:
  - If count>0, increment the hold counter.
  - When the hold counter reaches HOLD_FRAMES-1, zero it and advance tri_index = (tri_index+1) mod count, wrapping to 0 at count-1.
  - count==1 keeps index 0.
- frame_parity toggles on every fs, including commit frames.
- Output timing: geometry/color are registered from the active bank at tri_index. They are valid one clk after the tri_index update and stable for the whole frame. With count==0 they are forced to 0 and geom_valid=0.
- Shadow writes never alter geometry during a frame.
- Commit with wr_count=0 moves to IDLE at that fs.
- Reset mid-frame: everything returns to reset values on the next clk. A pending commit is discarded.

Optional Feature:
- Macro TRI_COLOR_EN.
- Defined: per-slot 3-bit colour stored alongside geometry; color follows the active triangle.
- Undefined: colour storage omitted, wr_color ignored, color = {1'b0, 1'b0, frame_parity} | 3'b001 when geom_valid, else 0.

Test Plan:
- Reset, vsync low→high twice -> geom_valid=0, geometry=0, tri_index=0, frame_parity toggles 0→1→0, wr_ready=1.
- Write slots 0,1 ({100,1,1,100,200,200}, {300,100,250,300,400,300}), commit_req with wr_count=2, HOLD_FRAMES=1 -> commit_done at the next vsync rise; geometry=slot0 one clk later; following frames alternate slot1, slot0; tri_index 1,0.
- HOLD_FRAMES=3, count=3 -> tri_index sequence 0,0,0,1,1,1,2,2,2,0 over ten frame starts.
- While displaying bank A, write slot 0 of shadow mid-frame -> geometry unchanged until commit; commit_req twice before fs -> single commit_done; wr_ready=0 between commit_req and commit_done.
- Commit with wr_count=0 while running -> at next fs geom_valid=0, geometry=0; wr_count=7 with MAX_TRIS=4 -> saturates, index wraps at 3.
- Assert reset for one cycle while a commit is pending -> no commit_done at the next fs, outputs at reset values, wr_ready=1.
